// File: rtl/tpg_ppc.sv
// Video timing pattern generator producing HS/VS/DE and active coordinates
// at 1, 2 or 4 pixels per clock, with frame-boundary reconfiguration.
module tpg_ppc #(
   parameter int PPC          = 1,
   parameter int CNT_W        = 16,
   parameter int VS_ALLIGN_EN = 0
) (
   input  logic             PIXEL_CLK_I,
   input  logic             RESETN_I,
   input  logic             EN_I,
   input  logic [CNT_W-1:0] HSYNC_I,
   input  logic [CNT_W-1:0] HBP_I,
   input  logic [CNT_W-1:0] HACTIVE_I,
   input  logic [CNT_W-1:0] HFP_I,
   input  logic [CNT_W-1:0] VSYNC_I,
   input  logic [CNT_W-1:0] VBP_I,
   input  logic [CNT_W-1:0] VACTIVE_I,
   input  logic [CNT_W-1:0] VFP_I,
   input  logic [2:0]       POL_I,
   input  logic             UPDATE_I,
   input  logic             VS_ALLIGN_I,
   output logic             HS_O,
   output logic             VS_O,
   output logic             DE_O,
   output logic [CNT_W-1:0] ACTIVE_X_O,
   output logic [CNT_W-1:0] ACTIVE_Y_O,
   output logic [15:0]      FRAME_CNT_O,
   output logic             UPDATE_DONE_O,
   output logic             CFG_ERR_O
);
   localparam int SH = (PPC == 4) ? 2 : (PPC == 2) ? 1 : 0;
   localparam int W2 = CNT_W + 2;
   localparam logic [CNT_W-1:0] PMASK = CNT_W'(PPC - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

   // Reset asserts asynchronously but releases two clocks later.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n;
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge PIXEL_CLK_I or negedge RESETN_I)
      if (!RESETN_I) rst_sync_q <= 2'b00;
      else           rst_sync_q <= rst_sync_d;

   // Shadow fields: 0 hsync, 1 hbp, 2 hact, 3 hfp, 4 vsync, 5 vbp, 6 vact, 7 vfp
   logic [7:0][CNT_W-1:0] cfg_q, cfg_d, cfg_in;
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      x_q, x_d, y_q, y_d, ax_q, ax_d, ay_q, ay_d;
   logic [15:0]           fc_q, fc_d;
   logic                  valid_q, valid_d, ld_q, ld_d, udone_q, udone_d, err_q, err_d;
   logic                  al_q, al_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d;

   assign cfg_in = {VFP_I, VACTIVE_I, VBP_I, VSYNC_I, HFP_I, HACTIVE_I, HBP_I, HSYNC_I};

   logic [W2-1:0] htot_w, vtot_w;
   logic          cfg_ok;
   assign htot_w = W2'(HSYNC_I) + W2'(HBP_I) + W2'(HACTIVE_I) + W2'(HFP_I);
   assign vtot_w = W2'(VSYNC_I) + W2'(VBP_I) + W2'(VACTIVE_I) + W2'(VFP_I);
   assign cfg_ok = (((HSYNC_I | HBP_I | HACTIVE_I | HFP_I) & PMASK) == '0) &&
                   (HACTIVE_I != '0) && (VACTIVE_I != '0) &&
                   (HSYNC_I != '0) && (VSYNC_I != '0) &&
                   ((htot_w >> CNT_W) == '0) && ((vtot_w >> CNT_W) == '0);

   // Horizontal limits are in clocks, vertical limits in lines.
   logic [CNT_W-1:0] h_sync_c, h_ast_c, h_aend_c, h_last_c, v_ast, v_aend, v_last;
   assign h_sync_c = cfg_q[0] >> SH;
   assign h_ast_c  = (cfg_q[0] + cfg_q[1]) >> SH;
   assign h_aend_c = (cfg_q[0] + cfg_q[1] + cfg_q[2]) >> SH;
   assign h_last_c = ((cfg_q[0] + cfg_q[1] + cfg_q[2] + cfg_q[3]) >> SH) - CNT_W'(1);
   assign v_ast    = cfg_q[4] + cfg_q[5];
   assign v_aend   = v_ast + cfg_q[6];
   assign v_last   = v_aend + cfg_q[7] - CNT_W'(1);

   logic run, x_end, y_end, align, load_try;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      fc_d     = fc_q;
      cfg_d    = cfg_q;
      valid_d  = valid_q;
      err_d    = err_q;
      ld_d     = 1'b0;
      udone_d  = ld_q;
      al_d     = VS_ALLIGN_I;
      load_try = 1'b0;
      run      = (state_q != S_IDLE) && EN_I;
      x_end    = (x_q == h_last_c);
      y_end    = (y_q == v_last);
      align    = (VS_ALLIGN_EN != 0) && VS_ALLIGN_I && !al_q;

      case (state_q)
         S_IDLE: begin
            load_try = UPDATE_I;
            if (EN_I && valid_q) state_d = S_RUN;
         end
         default: begin
            if (!EN_I) begin
               state_d = S_IDLE;
               x_d     = '0;
               y_d     = '0;
            end else begin
               if (align) begin
                  x_d = '0;
                  y_d = '0;
               end else if (x_end) begin
                  x_d = '0;
                  if (y_end) begin
                     y_d  = '0;
                     fc_d = fc_q + 16'd1;
                  end else begin
                     y_d = y_q + CNT_W'(1);
                  end
               end else begin
                  x_d = x_q + CNT_W'(1);
               end
               // A pending update lands on whichever restart comes first.
               if (state_q == S_PEND && (align || (x_end && y_end))) begin
                  load_try = 1'b1;
                  state_d  = S_RUN;
               end else if (state_q == S_RUN && UPDATE_I) begin
                  state_d = S_PEND;
               end
            end
         end
      endcase

      if (load_try) begin
         if (cfg_ok) begin
            cfg_d   = cfg_in;
            valid_d = 1'b1;
            ld_d    = 1'b1;
            err_d   = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end

      hs_d = run && (x_q < h_sync_c);
      vs_d = run && (y_q < cfg_q[4]);
      de_d = run && (x_q >= h_ast_c) && (x_q < h_aend_c) && (y_q >= v_ast) && (y_q < v_aend);
      ax_d = de_d ? ((x_q - h_ast_c) << SH) : '0;
      ay_d = de_d ? (y_q - v_ast) : '0;
   end

   always_ff @(posedge PIXEL_CLK_I or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         fc_q    <= '0;
         cfg_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ld_q    <= 1'b0;
         udone_q <= 1'b0;
         al_q    <= 1'b1;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         de_q    <= 1'b0;
         ax_q    <= '0;
         ay_q    <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fc_q    <= fc_d;
         cfg_q   <= cfg_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         ld_q    <= ld_d;
         udone_q <= udone_d;
         al_q    <= al_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         de_q    <= de_d;
         ax_q    <= ax_d;
         ay_q    <= ay_d;
      end
   end

   // Polarity sits after the flops so it is live even while in reset.
   assign HS_O          = hs_q ^ POL_I[1];
   assign VS_O          = vs_q ^ POL_I[2];
   assign DE_O          = de_q ^ POL_I[0];
   assign ACTIVE_X_O    = ax_q;
   assign ACTIVE_Y_O    = ay_q;
   assign FRAME_CNT_O   = fc_q;
   assign UPDATE_DONE_O = udone_q;
   assign CFG_ERR_O     = err_q;
endmodule
